// File: rtl/circle_renderer.sv
// Purpose : multi-slot circle hit test; slots load via valid/ready into shadow, commit_in copies all to active.
// Latency : pixel result 4 register stages after sampling (S1..S4); load takes 3 cycles per accepted transfer.
// Backpress: pixel path never stalls; load_ready_out is low for the 2 cycles after an accept.
//
// Ports:
//   clk_in, rst_n_in                       clock, async active-low reset
//   load_valid_in/load_ready_out           load handshake
//   load_slot_in, load_x1/x2_in, load_y1/y2_in, load_en_in, load_outline_in, load_color_in
//   commit_in                              shadow -> active for all slots
//   valid_in, hcount_in, vcount_in         pixel stream in
//   valid_out, hcount_out, vcount_out      pixel stream out (delayed)
//   hit_mask_out, hit_out, hit_idx_out, color_out   per-pixel result
//
// Optional feature macro: CIRCLE_OUTLINE_EN (ring mode; RING_T used only when defined).
module circle_renderer #(
   parameter int NUM_CIRCLES = 4,
   parameter int H_WIDTH     = 11,
   parameter int V_WIDTH     = 10,
   parameter int COLOR_WIDTH = 24,
   parameter int RING_T      = 2,
   localparam int SLOT_W     = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   load_valid_in,
   output logic                   load_ready_out,
   input  logic [SLOT_W-1:0]      load_slot_in,
   input  logic [H_WIDTH-1:0]     load_x1_in,
   input  logic [H_WIDTH-1:0]     load_x2_in,
   input  logic [V_WIDTH-1:0]     load_y1_in,
   input  logic [V_WIDTH-1:0]     load_y2_in,
   input  logic                   load_en_in,
   input  logic                   load_outline_in,
   input  logic [COLOR_WIDTH-1:0] load_color_in,
   input  logic                   commit_in,
   input  logic                   valid_in,
   input  logic [H_WIDTH-1:0]     hcount_in,
   input  logic [V_WIDTH-1:0]     vcount_in,
   output logic                   valid_out,
   output logic [H_WIDTH-1:0]     hcount_out,
   output logic [V_WIDTH-1:0]     vcount_out,
   output logic [NUM_CIRCLES-1:0] hit_mask_out,
   output logic                   hit_out,
   output logic [SLOT_W-1:0]      hit_idx_out,
   output logic [COLOR_WIDTH-1:0] color_out
);

   localparam int R2_W = 2 * H_WIDTH;
   localparam int D2_W = 2 * H_WIDTH + 1;
   localparam int DY2_W = 2 * V_WIDTH;

   // Everything the compare stages need from a slot; centre is consumed in S1 only.
   typedef struct packed {
      logic                   en;
`ifdef CIRCLE_OUTLINE_EN
      logic                   outline;
      logic [R2_W-1:0]        ri2;
`endif
      logic [R2_W-1:0]        r2;
      logic [COLOR_WIDTH-1:0] color;
   } cmp_t;

   typedef enum logic [1:0] {IDLE, NORM, CALC} ld_state_t;

   // ---------------- load FSM ----------------
   ld_state_t              ld_state;
   logic [SLOT_W-1:0]      ld_slot;
   logic [H_WIDTH-1:0]     ld_x1, ld_x2, xmin, xmax;
   logic [V_WIDTH-1:0]     ld_y1, ld_y2, ymin, ymax;
   logic                   ld_en;
   logic [COLOR_WIDTH-1:0] ld_color;
`ifdef CIRCLE_OUTLINE_EN
   logic                   ld_outline;
`else
   logic                   unused_outline;
   assign unused_outline = load_outline_in ^ (RING_T != 0);
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ld_state       <= IDLE;
         load_ready_out <= 1'b1;
         ld_slot        <= '0;
         ld_x1          <= '0;
         ld_x2          <= '0;
         ld_y1          <= '0;
         ld_y2          <= '0;
         ld_en          <= 1'b0;
         ld_color       <= '0;
`ifdef CIRCLE_OUTLINE_EN
         ld_outline     <= 1'b0;
`endif
         xmin           <= '0;
         xmax           <= '0;
         ymin           <= '0;
         ymax           <= '0;
      end else begin
         case (ld_state)
            IDLE: begin
               if (load_valid_in && load_ready_out) begin
                  ld_slot        <= load_slot_in;
                  ld_x1          <= load_x1_in;
                  ld_x2          <= load_x2_in;
                  ld_y1          <= load_y1_in;
                  ld_y2          <= load_y2_in;
                  ld_en          <= load_en_in;
                  ld_color       <= load_color_in;
`ifdef CIRCLE_OUTLINE_EN
                  ld_outline     <= load_outline_in;
`endif
                  ld_state       <= NORM;
                  load_ready_out <= 1'b0;
               end
            end
            NORM: begin
               xmin     <= (ld_x1 < ld_x2) ? ld_x1 : ld_x2;
               xmax     <= (ld_x1 < ld_x2) ? ld_x2 : ld_x1;
               ymin     <= (ld_y1 < ld_y2) ? ld_y1 : ld_y2;
               ymax     <= (ld_y1 < ld_y2) ? ld_y2 : ld_y1;
               ld_state <= CALC;
            end
            CALC: begin
               ld_state       <= IDLE;
               load_ready_out <= 1'b1;
            end
            default: begin
               ld_state       <= IDLE;
               load_ready_out <= 1'b1;
            end
         endcase
      end
   end

   // ---------------- CALC arithmetic ----------------
   logic [H_WIDTH-1:0] calc_r;
   logic [H_WIDTH-1:0] calc_cx;
   logic [V_WIDTH-1:0] calc_cy;
   cmp_t               calc_cmp;
   logic               calc_wr;
`ifdef CIRCLE_OUTLINE_EN
   logic [H_WIDTH-1:0] calc_ri;
   assign calc_ri = calc_r - H_WIDTH'(RING_T);
`endif

   // Radius uses the x extent only; y extent only places the centre.
   assign calc_r  = (xmax - xmin) >> 1;
   assign calc_wr = (ld_state == CALC) && (int'(ld_slot) < NUM_CIRCLES);

   always_comb begin
      calc_cmp = '0;
      calc_cx  = '0;
      calc_cy  = '0;
      if (ld_en) begin
         calc_cx        = H_WIDTH'(({1'b0, xmin} + {1'b0, xmax}) >> 1);
         calc_cy        = V_WIDTH'(({1'b0, ymin} + {1'b0, ymax}) >> 1);
         calc_cmp.en    = 1'b1;
         calc_cmp.r2    = R2_W'(calc_r) * R2_W'(calc_r);
         calc_cmp.color = ld_color;
`ifdef CIRCLE_OUTLINE_EN
         calc_cmp.outline = ld_outline;
         calc_cmp.ri2     = (int'(calc_r) > RING_T) ? R2_W'(calc_ri) * R2_W'(calc_ri) : '0;
`endif
      end
   end

   // ---------------- shadow / active slot storage ----------------
   cmp_t               sh_cmp  [NUM_CIRCLES];
   logic [H_WIDTH-1:0] sh_cx   [NUM_CIRCLES];
   logic [V_WIDTH-1:0] sh_cy   [NUM_CIRCLES];
   cmp_t               act_cmp [NUM_CIRCLES];
   logic [H_WIDTH-1:0] act_cx  [NUM_CIRCLES];
   logic [V_WIDTH-1:0] act_cy  [NUM_CIRCLES];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_CIRCLES; i++) begin
            sh_cmp[i]  <= '0;
            sh_cx[i]   <= '0;
            sh_cy[i]   <= '0;
            act_cmp[i] <= '0;
            act_cx[i]  <= '0;
            act_cy[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CIRCLES; i++) begin
            if (calc_wr && ld_slot == SLOT_W'(i)) begin
               sh_cmp[i] <= calc_cmp;
               sh_cx[i]  <= calc_cx;
               sh_cy[i]  <= calc_cy;
            end
            // A commit coinciding with the shadow write forwards the fresh entry.
            if (commit_in) begin
               if (calc_wr && ld_slot == SLOT_W'(i)) begin
                  act_cmp[i] <= calc_cmp;
                  act_cx[i]  <= calc_cx;
                  act_cy[i]  <= calc_cy;
               end else begin
                  act_cmp[i] <= sh_cmp[i];
                  act_cx[i]  <= sh_cx[i];
                  act_cy[i]  <= sh_cy[i];
               end
            end
         end
      end
   end

   // ---------------- pixel pipeline ----------------
   // S1 snapshots the compare fields so in-flight pixels never see a later commit.
   logic               s1_v, s2_v, s3_v;
   logic [H_WIDTH-1:0] s1_h, s2_h, s3_h;
   logic [V_WIDTH-1:0] s1_vc, s2_vc, s3_vc;
   logic [H_WIDTH-1:0] s1_dx  [NUM_CIRCLES];
   logic [V_WIDTH-1:0] s1_dy  [NUM_CIRCLES];
   cmp_t               s1_cmp [NUM_CIRCLES];
   logic [R2_W-1:0]    s2_dx2 [NUM_CIRCLES];
   logic [DY2_W-1:0]   s2_dy2 [NUM_CIRCLES];
   cmp_t               s2_cmp [NUM_CIRCLES];
   logic [D2_W-1:0]    s2_d2  [NUM_CIRCLES];
   logic [NUM_CIRCLES-1:0] s3_hit;
   logic [COLOR_WIDTH-1:0] s3_color [NUM_CIRCLES];
   logic [NUM_CIRCLES-1:0] s2_hit;
   logic [SLOT_W-1:0]      pe_idx;
   logic [COLOR_WIDTH-1:0] pe_color;

   always_comb begin
      for (int i = 0; i < NUM_CIRCLES; i++) begin
         s2_d2[i]  = D2_W'(s2_dx2[i]) + D2_W'(s2_dy2[i]);
         s2_hit[i] = s2_v && s2_cmp[i].en && (s2_d2[i] <= D2_W'(s2_cmp[i].r2))
`ifdef CIRCLE_OUTLINE_EN
                     && (!s2_cmp[i].outline || (s2_d2[i] > D2_W'(s2_cmp[i].ri2)))
`endif
                     ;
      end
   end

   // Scan high to low so the lowest hit index is the one left standing.
   always_comb begin
      pe_idx   = '0;
      pe_color = '0;
      for (int i = NUM_CIRCLES - 1; i >= 0; i--) begin
         if (s3_hit[i]) begin
            pe_idx   = SLOT_W'(i);
            pe_color = s3_color[i];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
         s1_h <= '0;   s2_h <= '0;   s3_h <= '0;
         s1_vc <= '0;  s2_vc <= '0;  s3_vc <= '0;
         s3_hit <= '0;
         for (int i = 0; i < NUM_CIRCLES; i++) begin
            s1_dx[i]    <= '0;
            s1_dy[i]    <= '0;
            s1_cmp[i]   <= '0;
            s2_dx2[i]   <= '0;
            s2_dy2[i]   <= '0;
            s2_cmp[i]   <= '0;
            s3_color[i] <= '0;
         end
         valid_out    <= 1'b0;
         hcount_out   <= '0;
         vcount_out   <= '0;
         hit_mask_out <= '0;
         hit_out      <= 1'b0;
         hit_idx_out  <= '0;
         color_out    <= '0;
      end else begin
         // S1
         s1_v  <= valid_in;
         s1_h  <= hcount_in;
         s1_vc <= vcount_in;
         for (int i = 0; i < NUM_CIRCLES; i++) begin
            s1_dx[i]  <= (hcount_in >= act_cx[i]) ? hcount_in - act_cx[i] : act_cx[i] - hcount_in;
            s1_dy[i]  <= (vcount_in >= act_cy[i]) ? vcount_in - act_cy[i] : act_cy[i] - vcount_in;
            s1_cmp[i] <= act_cmp[i];
         end
         // S2
         s2_v  <= s1_v;
         s2_h  <= s1_h;
         s2_vc <= s1_vc;
         for (int i = 0; i < NUM_CIRCLES; i++) begin
            s2_dx2[i] <= R2_W'(s1_dx[i]) * R2_W'(s1_dx[i]);
            s2_dy2[i] <= DY2_W'(s1_dy[i]) * DY2_W'(s1_dy[i]);
            s2_cmp[i] <= s1_cmp[i];
         end
         // S3
         s3_v   <= s2_v;
         s3_h   <= s2_h;
         s3_vc  <= s2_vc;
         s3_hit <= s2_hit;
         for (int i = 0; i < NUM_CIRCLES; i++) begin
            s3_color[i] <= s2_cmp[i].color;
         end
         // S4
         valid_out    <= s3_v;
         hcount_out   <= s3_h;
         vcount_out   <= s3_vc;
         hit_mask_out <= s3_hit;
         hit_out      <= |s3_hit;
         hit_idx_out  <= pe_idx;
         color_out    <= pe_color;
      end
   end

endmodule

// File: tb/tb_circle_renderer.sv
// Purpose : directed bench for circle_renderer with a model-fed scoreboard.
// Latency : expects results 4 register stages after a pixel is sampled.
// Backpress: drives loads only when load_ready_out is high, bounded waits.
module tb_circle_renderer;
   localparam int N  = 4;
   localparam int HW = 11;
   localparam int VW = 10;
   localparam int CW = 24;
   localparam int RT = 2;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          load_valid_in, load_ready_out;
   logic [1:0]    load_slot_in;
   logic [HW-1:0] load_x1_in, load_x2_in;
   logic [VW-1:0] load_y1_in, load_y2_in;
   logic          load_en_in, load_outline_in;
   logic [CW-1:0] load_color_in;
   logic          commit_in, valid_in;
   logic [HW-1:0] hcount_in, hcount_out;
   logic [VW-1:0] vcount_in, vcount_out;
   logic          valid_out, hit_out;
   logic [N-1:0]  hit_mask_out;
   logic [1:0]    hit_idx_out;
   logic [CW-1:0] color_out;

   circle_renderer #(.NUM_CIRCLES(N), .H_WIDTH(HW), .V_WIDTH(VW), .COLOR_WIDTH(CW), .RING_T(RT)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .load_valid_in(load_valid_in), .load_ready_out(load_ready_out),
      .load_slot_in(load_slot_in), .load_x1_in(load_x1_in), .load_x2_in(load_x2_in),
      .load_y1_in(load_y1_in), .load_y2_in(load_y2_in), .load_en_in(load_en_in),
      .load_outline_in(load_outline_in), .load_color_in(load_color_in),
      .commit_in(commit_in), .valid_in(valid_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .valid_out(valid_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hit_mask_out(hit_mask_out), .hit_out(hit_out), .hit_idx_out(hit_idx_out),
      .color_out(color_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int cx; int cy; longint r2; longint ri2; bit en; bit outl; int color;
   } slot_m;
   typedef struct {
      int h; int v; int mask; int idx; int color; int cyc;
   } exp_t;

   slot_m m_sh[N];
   slot_m m_act[N];
   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(string tag, longint obs, longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < N; i++) begin
         m_sh[i]  = '{default: 0};
         m_act[i] = '{default: 0};
      end
   endfunction

   function automatic void m_load(int slot, int x1, int y1, int x2, int y2, bit en, bit outl, int color);
      slot_m s;
      int xmin, xmax, ymin, ymax, r;
      if (slot >= N) return;
      s = '{default: 0};
      if (en) begin
         xmin = (x1 < x2) ? x1 : x2;  xmax = (x1 < x2) ? x2 : x1;
         ymin = (y1 < y2) ? y1 : y2;  ymax = (y1 < y2) ? y2 : y1;
         r      = (xmax - xmin) / 2;
         s.cx   = (xmin + xmax) / 2;
         s.cy   = (ymin + ymax) / 2;
         s.r2   = longint'(r) * r;
         s.ri2  = (r > RT) ? longint'(r - RT) * (r - RT) : 0;
         s.en   = 1'b1;
         s.color = color;
`ifdef CIRCLE_OUTLINE_EN
         s.outl = outl;
`else
         s.outl = 1'b0;
`endif
      end
      m_sh[slot] = s;
   endfunction

   function automatic exp_t m_pixel(int h, int v);
      exp_t e;
      e = '{default: 0};
      e.h = h; e.v = v;
      for (int i = N - 1; i >= 0; i--) begin
         int dx, dy;
         longint d2;
         dx = h - m_act[i].cx; if (dx < 0) dx = -dx;
         dy = v - m_act[i].cy; if (dy < 0) dy = -dy;
         d2 = longint'(dx) * dx + longint'(dy) * dy;
         if (m_act[i].en && d2 <= m_act[i].r2 && (!m_act[i].outl || d2 > m_act[i].ri2)) begin
            e.mask  = e.mask | (1 << i);
            e.idx   = i;
            e.color = m_act[i].color;
         end
      end
      return e;
   endfunction

   // One clock: optional pixel and/or commit; expectation uses the set before the commit edge.
   task automatic step(bit pv, int h, int v, bit cm);
      exp_t e;
      valid_in  = pv;
      hcount_in = h[HW-1:0];
      vcount_in = v[VW-1:0];
      commit_in = cm;
      if (pv) begin
         e = m_pixel(h, v);
         e.cyc = cyc + 4;
         sb.push_back(e);
      end
      if (cm) m_act = m_sh;
      @(posedge clk_in); #1;
      valid_in  = 1'b0;
      commit_in = 1'b0;
   endtask

   task automatic set_load(int slot, int x1, int y1, int x2, int y2, bit en, bit outl, int color);
      load_slot_in    = slot[1:0];
      load_x1_in      = x1[HW-1:0];
      load_y1_in      = y1[VW-1:0];
      load_x2_in      = x2[HW-1:0];
      load_y2_in      = y2[VW-1:0];
      load_en_in      = en;
      load_outline_in = outl;
      load_color_in   = color[CW-1:0];
   endtask

   task automatic load(int slot, int x1, int y1, int x2, int y2, bit en, bit outl, int color, bit wait_done);
      int n = 0;
      while (!load_ready_out && n < 20) begin @(posedge clk_in); #1; n++; end
      chk("load_ready_before_accept", load_ready_out, 1);
      set_load(slot, x1, y1, x2, y2, en, outl, color);
      load_valid_in = 1'b1;
      @(posedge clk_in); #1;
      load_valid_in = 1'b0;
      m_load(slot, x1, y1, x2, y2, en, outl, color);
      if (wait_done) begin
         repeat (2) begin @(posedge clk_in); #1; end
         chk("load_ready_after_load", load_ready_out, 1);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 10) begin @(posedge clk_in); #1; n++; end
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   // Output monitor: pops one expectation per valid result.
   always @(negedge clk_in) begin
      if (rst_n_in) begin
         if (!valid_out) begin
            chk("mask_zero_when_invalid", hit_mask_out, 0);
         end else begin
            chk("result_was_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("latency_cycle", cyc, e.cyc);
               chk("hcount_out", hcount_out, e.h);
               chk("vcount_out", vcount_out, e.v);
               chk("hit_mask_out", hit_mask_out, e.mask);
               chk("hit_out", hit_out, (e.mask != 0));
               chk("hit_idx_out", hit_idx_out, e.idx);
               chk("color_out", color_out, e.color);
            end
         end
      end
   end

   initial begin
      #100000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat[7];
      pat = '{1, 0, 0, 1, 0, 0, 1};
      rst_n_in = 1'b0;
      load_valid_in = 1'b0; commit_in = 1'b0; valid_in = 1'b0;
      hcount_in = '0; vcount_in = '0;
      set_load(0, 0, 0, 0, 0, 0, 0, 0);
      m_clear();
      #12;
      chk("rst_load_ready", load_ready_out, 1);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_hit_out", hit_out, 0);
      chk("rst_color_out", color_out, 0);
      repeat (3) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      chk("post_rst_mask", hit_mask_out, 0);
      chk("post_rst_hcount", hcount_out, 0);

      // Basic disc in slot 0.
      load(0, 100, 100, 140, 140, 1, 0, 'hFF0000, 1);
      step(0, 0, 0, 1);
      step(1, 120, 120, 0);
      step(1, 141, 120, 0);
      step(1, 140, 120, 0);
      drain();

      // Overlap with reversed corners.
      load(2, 160, 160, 100, 100, 1, 0, 'h00FF00, 1);
      step(0, 0, 0, 1);
      step(1, 125, 125, 0);
      step(1, 155, 130, 0);
      drain();

      // Load without commit, then commit mid-stream.
      load(1, 200, 200, 220, 220, 1, 0, 'h0000FF, 1);
      step(1, 210, 210, 0);
      step(1, 210, 210, 0);
      step(1, 210, 210, 1);
      step(1, 210, 210, 0);
      step(1, 210, 210, 0);
      drain();

      // Back-to-back loads with valid held high.
      set_load(3, 300, 50, 320, 70, 1, 0, 'hABCDEF);
      load_valid_in = 1'b1;
      for (int k = 0; k < 7; k++) begin
         chk("b2b_ready_pattern", load_ready_out, pat[k]);
         @(posedge clk_in); #1;
         if (k == 0) begin
            m_load(3, 300, 50, 320, 70, 1, 0, 'hABCDEF);
            set_load(1, 0, 0, 0, 0, 0, 0, 0);
         end
         if (k == 3) begin
            m_load(1, 0, 0, 0, 0, 0, 0, 0);
            load_valid_in = 1'b0;
         end
      end
      step(0, 0, 0, 1);
      step(1, 310, 60, 0);
      step(1, 210, 210, 0);
      step(0, 310, 60, 0);
      step(1, 125, 125, 0);
      drain();

      // Ring in slot 0; commit lands on the shadow-write edge.
      load(0, 0, 0, 20, 20, 1, 1, 'h123456, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(1, 10, 10, 0);
      step(1, 20, 10, 0);
      step(1, 0, 10, 0);
      step(1, 21, 10, 0);
      step(1, 10, 18, 0);
      step(1, 10, 19, 0);
      drain();

      // Zero radius and a large radius with equality on the boundary.
      load(2, 400, 300, 400, 300, 1, 0, 'h0F0F0F, 1);
      load(1, 0, 0, 2046, 0, 1, 0, 'h777777, 1);
      step(0, 0, 0, 1);
      step(1, 400, 300, 0);
      step(1, 401, 300, 0);
      step(1, 400, 301, 0);
      step(1, 1023, 1023, 0);
      step(1, 2047, 1023, 0);
      drain();

      // Reset during NORM with pixels in flight.
      step(1, 310, 60, 0);
      step(1, 310, 60, 0);
      step(1, 310, 60, 0);
      chk("load_ready_before_abort", load_ready_out, 1);
      set_load(0, 300, 50, 320, 70, 1, 0, 'h555555);
      load_valid_in = 1'b1;
      step(1, 310, 60, 0);
      load_valid_in = 1'b0;
      chk("valid_out_pre_reset", valid_out, 1);
      #1 rst_n_in = 1'b0;
      #1;
      chk("abort_valid_out", valid_out, 0);
      chk("abort_hit_out", hit_out, 0);
      chk("abort_mask", hit_mask_out, 0);
      chk("abort_color", color_out, 0);
      chk("abort_hcount", hcount_out, 0);
      chk("abort_load_ready", load_ready_out, 1);
      sb.delete();
      m_clear();
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      repeat (3) begin @(posedge clk_in); #1; end
      chk("after_abort_ready", load_ready_out, 1);
      step(1, 310, 60, 1);
      step(1, 310, 60, 0);
      step(1, 120, 120, 0);
      step(1, 1023, 1023, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/circle_renderer.md
# circle_renderer

Multi-slot, parametrised successor to the single-circle pixel test. It holds NUM_CIRCLES circles, each loaded as two bounding-box corners through a valid/ready load port into shadow registers, and commits all slots to the active set atomically. Each pixel of the hcount/vcount stream is tested against every enabled active circle in a fixed-latency pipeline, which returns the hit mask, the winning slot index and that slot's colour. It sits between the object/physics state and the video compositor.

## Interface
- NUM_CIRCLES, 4: number of circle slots, ≥1.
- H_WIDTH, 11: width of hcount and x coordinates.
- V_WIDTH, 10: width of vcount and y coordinates.
- COLOR_WIDTH, 24: per-slot colour width.
- RING_T, 2: outline thickness in pixels. Used only when CIRCLE_OUTLINE_EN is defined.
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n_in  input  1  reset, asynchronous and active-low. One clock; reset is asynchronous, active-low.
- load_valid_in  input  1  load request.
- load_ready_out  output  1  load port can accept.
- load_slot_in  input  clog2(NUM_CIRCLES) (min 1)  target slot.
- load_x1_in, load_x2_in  input  H_WIDTH  corner x coordinates, in any order.
- load_y1_in, load_y2_in  input  V_WIDTH  corner y coordinates, in any order.
- load_en_in  input  1  slot enable; 0 clears the slot.
- load_outline_in  input  1  draw as a ring rather than a disc.
- load_color_in  input  COLOR_WIDTH  slot colour.
- commit_in  input  1  pulse that copies shadow to active.
- valid_in  input  1  pixel valid.
- hcount_in  input  H_WIDTH  pixel x.
- vcount_in  input  V_WIDTH  pixel y.
- valid_out  output  1  pixel result valid.
- hcount_out, vcount_out  output  H_WIDTH/V_WIDTH  pixel coordinates, delayed to match the result.
- hit_mask_out  output  NUM_CIRCLES  per-slot hit.
- hit_out  output  1  |hit_mask_out.
- hit_idx_out  output  clog2(NUM_CIRCLES)  lowest hit slot; 0 if there is no hit.
- color_out  output  COLOR_WIDTH  colour of the hit_idx_out slot; 0 if there is no hit.

## Operation
- Load FSM has three states: IDLE → NORM → CALC → IDLE. load_ready_out is 1 only in IDLE.
- IDLE: a transfer is accepted when valid and ready are both high. All load inputs are registered and the FSM moves to NORM.
- NORM: compute xmin/xmax and ymin/ymax.
- CALC:
  - Compute cx = (xmin+xmax)>>1, cy = (ymin+ymax)>>1, r = (xmax−xmin)>>1 and r² (2·H_WIDTH bits).
  - With outline: also compute ri² = (r−RING_T)², or 0 when r ≤ RING_T.
  - Write the slot's shadow entry and return to IDLE.
- Radius comes from the x extent only; the y extent affects only the centre.
- Commit: at the edge sampling commit_in=1, active ← shadow for all slots. If CALC writes in the same cycle, the new entry is forwarded into active.
- Pixel test for slot i:
  - dx = |hcount − cx|, dy = |vcount − cy|.
  - d² = dx² + dy², held at 2·H_WIDTH+1 bits with no truncation.
  - Hit = en_i ∧ d² ≤ r²_i ∧ (¬outline_i ∨ d² > ri²_i).
- Priority: the lowest index wins.
- Pixels with valid_in=0 still flow through the pipeline, but valid_out=0 and hit_mask_out is forced to 0 for them.

## Timing
- Pixel latency is exactly 4 cycles:
  - S1: abs diffs; snapshot active r², ri², outline and en.
  - S2: squares.
  - S3: sum and compare.
  - S4: priority encode and colour mux.
- Throughput: 1 pixel per clock, no stalls.
- Commit: pixels entering S1 on the cycle after the commit edge use the new set. Pixels already in flight complete with the old set, with no mixing.
- Load: accept at edge k; shadow is written at edge k+2; ready returns high at k+2, giving 1 accept per 3 cycles.
- Reset (asynchronous assert, synchronous use after deassert):
  - FSM → IDLE, load_ready_out=1.
  - All shadow and active slots disabled and zeroed.
  - Pipeline valids = 0.
  - Every output = 0 except load_ready_out.
- Reset asserted mid-load aborts the load with no shadow write.
- A load to a slot number ≥ NUM_CIRCLES is accepted and dropped.
- Coordinate equal corners give r = 0: only the centre pixel hits.

## Configuration
- CIRCLE_OUTLINE_EN:
  - Defined: ring mode exists; ri² is computed and stored; load_outline_in is honoured.
  - Undefined: no ri² storage or compare logic; load_outline_in is ignored; every enabled slot is a filled disc.
  - Port list is identical in both cases.

## Test plan
- Load slot 0: (100,100),(140,140), en=1, colour FF0000; commit; pixel (120,120). → After 4 cycles: hit_out=1, hit_idx_out=0, color_out=FF0000. Pixel (141,120) → no hit, color_out=0.
- Slot 0 and slot 2 overlapping with reversed corners: slot 2 load (160,160),(100,100); commit; pixel (125,125). → hit_mask_out=0101, hit_idx_out=0.
- Load without commit. → Pixels show the old set. Commit while pixels stream → the switch happens exactly at the pixel entering S1 after the commit edge.
- Back-to-back loads held at valid=1. → load_ready_out pattern is 1,0,0,1,…; 3-cycle spacing; both slots written.
- Outline on, RING_T=2, box (0,0),(20,20) (r=10, centre (10,10)), run with and without CIRCLE_OUTLINE_EN:
  - Pixel (10,10): no hit with the macro, hit without it.
  - Pixel (20,10): hit in both.
- Assert rst_n_in in NORM with pixels in flight. → Outputs go to 0 immediately, load_ready_out=1, no slot is written, and subsequent pixels miss.
